// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard.
// Entry layout, stall_cause bit positions and the Tnew saturating step.
package hazard_pkg;

  localparam int unsigned TwDef = 3;
  localparam logic [4:0]  EpcReg = 5'd14;

  localparam int unsigned CauseRs   = 0;
  localparam int unsigned CauseRt   = 1;
  localparam int unsigned CauseMdu  = 2;
  localparam int unsigned CauseEret = 3;

  typedef struct packed {
    logic             valid;
    logic [4:0]       wa;
    logic [TwDef-1:0] tnew;
    logic             epc_wr;
  } entry_t;

  function automatic logic [TwDef-1:0] sat_dec(input logic [TwDef-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_entry_cmp.sv
// Compares one in-flight entry against the D-stage sources.
// An entry with tnew=0 can always forward, so it never produces a hit.
module hazard_entry_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned TW = TwDef
) (
  input  entry_t        entry,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [TW-1:0] tuse_rs,
  input  logic [TW-1:0] tuse_rt,
  output logic          rs_hit,
  output logic          rt_hit,
  output logic          epc_hit
);

  logic [TW-1:0] tnew;
  logic          live;

  assign tnew = TW'(entry.tnew);
  assign live = entry.valid && (entry.wa != 5'd0);

  // An all-ones Tuse can never be below tnew, which covers "not used".
  assign rs_hit  = live && (entry.wa == rs) && (tuse_rs < tnew);
  assign rt_hit  = live && (entry.wa == rt) && (tuse_rt < tnew);
  assign epc_hit = entry.valid && entry.epc_wr;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the D stage: data, MDU and eret/EPC stalls,
// plus a saturating count of stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TW       = TwDef,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic [4:0]       d_wa,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_mdu_use,
  input  logic             d_md_start,
  input  logic             d_md_div,
  input  logic             d_epc_wr,
  input  logic             d_eret,
  input  logic             flush,
  output logic             stall,
  output logic [3:0]       stall_cause,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MduMax = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned MduW   = $clog2(MduMax + 1);

  entry_t entry_q [NSTAGE];
  entry_t entry_d [NSTAGE];

  logic [NSTAGE-1:0] rs_hit, rt_hit, epc_hit;
  logic [3:0]        haz;
  logic              accept;
  logic [MduW-1:0]   mdu_q, mdu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_cmp
    hazard_entry_cmp #(
      .TW (TW)
    ) u_cmp (
      .entry   (entry_q[gi]),
      .rs      (d_rs),
      .rt      (d_rt),
      .tuse_rs (d_tuse_rs),
      .tuse_rt (d_tuse_rt),
      .rs_hit  (rs_hit[gi]),
      .rt_hit  (rt_hit[gi]),
      .epc_hit (epc_hit[gi])
    );
  end

  assign mdu_busy = (mdu_q != '0);

  always_comb begin
    haz            = '0;
    haz[CauseRs]   = |rs_hit;
    haz[CauseRt]   = |rt_hit;
    haz[CauseMdu]  = d_mdu_use && mdu_busy;
    haz[CauseEret] = d_eret && (|epc_hit);
  end

  assign stall       = reset && d_valid && !flush && (|haz);
  assign stall_cause = haz & {4{stall}};
  assign accept      = d_valid && !stall && !flush;
  assign stall_cnt   = cnt_q;

  always_comb begin
    entry_d[0] = '0;
    if (accept) begin
      entry_d[0].valid  = 1'b1;
      entry_d[0].wa     = d_wa;
      entry_d[0].tnew   = TwDef'(d_tnew);
      entry_d[0].epc_wr = d_epc_wr;
    end
    for (int k = 1; k < NSTAGE; k++) begin
      entry_d[k]      = entry_q[k-1];
      entry_d[k].tnew = sat_dec(entry_q[k-1].tnew);
    end
    if (flush) begin
      for (int k = 0; k < NSTAGE; k++) begin
        entry_d[k] = '0;
      end
    end
  end

  // A new md operation replaces whatever count is left; flush does not stop the MDU.
  always_comb begin
    mdu_d = mdu_q;
    if (accept && d_md_start) begin
      mdu_d = d_md_div ? MduW'(DIV_LAT) : MduW'(MULT_LAT);
    end else if (mdu_q != '0) begin
      mdu_d = mdu_q - 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        entry_q[k] <= '0;
      end
      mdu_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        entry_q[k] <= entry_d[k];
      end
      mdu_q <= mdu_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, forwarding, MDU, eret/EPC,
// flush and mid-operation reset, with hand-computed expected values.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_mdu_use, d_md_start, d_md_div, d_epc_wr, d_eret, flush;
  logic        stall;
  logic [3:0]  stall_cause;
  logic        mdu_busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_wa        (d_wa),
    .d_tnew      (d_tnew),
    .d_mdu_use   (d_mdu_use),
    .d_md_start  (d_md_start),
    .d_md_div    (d_md_div),
    .d_epc_wr    (d_epc_wr),
    .d_eret      (d_eret),
    .flush       (flush),
    .stall       (stall),
    .stall_cause (stall_cause),
    .mdu_busy    (mdu_busy),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_d();
    d_valid    = 1'b0;
    d_rs       = 5'd0;
    d_rt       = 5'd0;
    d_tuse_rs  = 3'b111;
    d_tuse_rt  = 3'b111;
    d_wa       = 5'd0;
    d_tnew     = 3'd0;
    d_mdu_use  = 1'b0;
    d_md_start = 1'b0;
    d_md_div   = 1'b0;
    d_epc_wr   = 1'b0;
    d_eret     = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    clear_d();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_cause", 32'(stall_cause), 0);
    check_eq("rst_busy", 32'(mdu_busy), 0);
    check_eq("rst_cnt", stall_cnt, 0);
    reset = 1'b1;
    step();

    // lw $1 enters E with tnew=2; beq on $1 (tuse=0) waits two cycles
    d_valid = 1'b1; d_wa = 5'd1; d_tnew = 3'd2; d_rs = 5'd3; d_tuse_rs = 3'd1;
    @(negedge clk);
    check_eq("lw_issue", 32'(stall), 0);
    step();
    clear_d();
    d_valid = 1'b1; d_rs = 5'd1; d_tuse_rs = 3'd0; d_rt = 5'd4; d_tuse_rt = 3'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("lw_use_stall", 32'(stall), 1);
      check_eq("lw_use_cause", 32'(stall_cause), 32'b0001);
      step();
    end
    @(negedge clk);
    check_eq("lw_use_release", 32'(stall), 0);
    check_eq("lw_use_cnt", stall_cnt, 2);
    step();

    // addu $2 tnew=1 then sw with rt=$2 tuse=2: no stall; tuse=0 would stall on rt
    clear_d();
    d_valid = 1'b1; d_wa = 5'd2; d_tnew = 3'd1; d_rs = 5'd5; d_tuse_rs = 3'd1;
    @(negedge clk);
    check_eq("addu_issue", 32'(stall), 0);
    step();
    clear_d();
    d_valid = 1'b1; d_rs = 5'd6; d_tuse_rs = 3'd1; d_rt = 5'd2; d_tuse_rt = 3'd2;
    @(negedge clk);
    check_eq("sw_no_stall", 32'(stall), 0);
    d_tuse_rt = 3'd0;
    #1;
    check_eq("rt_stall", 32'(stall), 1);
    check_eq("rt_cause", 32'(stall_cause), 32'b0010);
    step();
    @(negedge clk);
    check_eq("rt_fwd", 32'(stall), 0);
    check_eq("rt_cnt", stall_cnt, 3);
    step();

    // div accepted, then mfhi waits DIV_LAT=10 cycles
    clear_d();
    d_valid = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    @(negedge clk);
    check_eq("div_idle_busy", 32'(mdu_busy), 0);
    check_eq("div_issue", 32'(stall), 0);
    step();
    clear_d();
    d_valid = 1'b1; d_mdu_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("mdu_stall", 32'(stall), 1);
      check_eq("mdu_cause", 32'(stall_cause), 32'b0100);
      check_eq("mdu_busy", 32'(mdu_busy), 1);
      step();
    end
    @(negedge clk);
    check_eq("mdu_release", 32'(stall), 0);
    check_eq("mdu_idle", 32'(mdu_busy), 0);
    check_eq("mdu_cnt", stall_cnt, 13);
    step();

    // mtc0 EPC reaches M, then eret in D must wait for it
    clear_d();
    d_valid = 1'b1; d_epc_wr = 1'b1;
    @(negedge clk);
    check_eq("mtc0_issue", 32'(stall), 0);
    step();
    clear_d();
    step();
    d_valid = 1'b1; d_eret = 1'b1;
    @(negedge clk);
    check_eq("eret_stall", 32'(stall), 1);
    check_eq("eret_cause", 32'(stall_cause), 32'b1000);
    step();
    step();
    @(negedge clk);
    check_eq("eret_release", 32'(stall), 0);
    step();

    // flush during a load-use stall, from a known zero count
    clear_d();
    reset = 1'b0;
    #1;
    check_eq("rst2_cnt", stall_cnt, 0);
    reset = 1'b1;
    step();
    d_valid = 1'b1; d_wa = 5'd1; d_tnew = 3'd2;
    step();
    clear_d();
    d_valid = 1'b1; d_rs = 5'd1; d_tuse_rs = 3'd0;
    @(negedge clk);
    check_eq("pre_flush_stall", 32'(stall), 1);
    step();
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_stall", 32'(stall), 0);
    check_eq("flush_cause", 32'(stall_cause), 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("post_flush_stall", 32'(stall), 0);
    check_eq("flush_cnt", stall_cnt, 1);
    step();

    // reset in the middle of a mult countdown aborts it
    clear_d();
    d_valid = 1'b1; d_md_start = 1'b1;
    step();
    clear_d();
    d_valid = 1'b1; d_mdu_use = 1'b1;
    @(negedge clk);
    check_eq("mult_busy", 32'(mdu_busy), 1);
    check_eq("mult_stall", 32'(stall), 1);
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(mdu_busy), 0);
    check_eq("rst_mid_stall", 32'(stall), 0);
    check_eq("rst_mid_cnt", stall_cnt, 0);
    reset = 1'b1;
    step();
    @(negedge clk);
    check_eq("mult_aborted", 32'(stall), 0);
    check_eq("mult_aborted_busy", 32'(mdu_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
